// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side signal bundle for sram_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the SRAM macro.
interface sram_arbiter_if #(
    parameter int BW = 32,
    parameter int AW = 10
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] a0;
    logic [BW-1:0] di0;
    logic          gnt0;
    logic          rvalid0;
    logic [BW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] a1;
    logic [BW-1:0] di1;
    logic          gnt1;
    logic          rvalid1;
    logic [BW-1:0] rdata1;

    logic          csn;
    logic          wen;
    logic [AW-1:0] a;
    logic [BW-1:0] di;
    logic [BW-1:0] dout;

    modport slave (
        input  req0, we0, a0, di0,
        input  req1, we1, a1, di1,
        input  dout,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output csn, wen, a, di
    );

    modport master (
        output req0, we0, a0, di0,
        output req1, we1, a1, di1,
        output dout,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  csn, wen, a, di
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous SRAM with a one-cycle registered read.
// Grants are combinational; read-valid flags are registered so they line up with the SRAM output.
module sram_arbiter #(
    parameter int BW = 32,
    parameter int AW = 10,
    parameter int RR = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sram_arbiter_if.slave  bus
);

    logic          last_q;
    logic          rvalid0_q;
    logic          rvalid0_d;
    logic          rvalid1_q;
    logic          rvalid1_d;
    logic          gnt0_s;
    logic          gnt1_s;
    logic          wen_s;
    logic [AW-1:0] a_s;
    logic [BW-1:0] di_s;

    // Grant selection; last_q=1 out of reset makes port 0 win the first contested cycle.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst_i) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (bus.req0 && bus.req1) begin
            if (RR != 0) begin
                gnt0_s = last_q;
                gnt1_s = ~last_q;
            end else begin
                gnt0_s = 1'b1;
                gnt1_s = 1'b0;
            end
        end else if (bus.req0) begin
            gnt0_s = 1'b1;
        end else if (bus.req1) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // SRAM command mux; with no grant the port-0 address/data are passed through.
    always_comb begin
        wen_s = 1'b1;
        a_s   = bus.a0;
        di_s  = bus.di0;
        if (gnt1_s) begin
            wen_s = ~bus.we1;
            a_s   = bus.a1;
            di_s  = bus.di1;
        end else if (gnt0_s) begin
            wen_s = ~bus.we0;
        end else begin
            wen_s = 1'b1;
        end
    end

    // A granted read raises the owner's valid flag in the cycle the SRAM presents DOUT.
    always_comb begin
        rvalid0_d = gnt0_s & ~bus.we0;
        rvalid1_d = gnt1_s & ~bus.we1;
    end

    // Priority pointer and read-valid registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            if (gnt0_s || gnt1_s) begin
                last_q <= gnt1_s;
            end
        end
    end

    assign bus.gnt0    = gnt0_s;
    assign bus.gnt1    = gnt1_s;
    assign bus.csn     = ~(gnt0_s | gnt1_s);
    assign bus.wen     = wen_s;
    assign bus.a       = a_s;
    assign bus.di      = di_s;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = bus.dout;
    assign bus.rdata1  = bus.dout;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a round-robin and a fixed-priority instance share the same requester
// stimulus, each with its own SRAM model, checked against a per-cycle reference of the grant rules.
module tb_sram_arbiter;
    localparam int BW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] a0, a1;
    logic [BW-1:0] di0, di1;

    int n_cmp = 0;
    int n_err = 0;

    sram_arbiter_if #(.BW(BW), .AW(AW)) bus_rr ();
    sram_arbiter_if #(.BW(BW), .AW(AW)) bus_fp ();

    assign bus_rr.req0 = req0;  assign bus_fp.req0 = req0;
    assign bus_rr.we0  = we0;   assign bus_fp.we0  = we0;
    assign bus_rr.a0   = a0;    assign bus_fp.a0   = a0;
    assign bus_rr.di0  = di0;   assign bus_fp.di0  = di0;
    assign bus_rr.req1 = req1;  assign bus_fp.req1 = req1;
    assign bus_rr.we1  = we1;   assign bus_fp.we1  = we1;
    assign bus_rr.a1   = a1;    assign bus_fp.a1   = a1;
    assign bus_rr.di1  = di1;   assign bus_fp.di1  = di1;

    sram_arbiter #(.BW(BW), .AW(AW), .RR(1)) dut_rr (.clk_i(clk), .rst_i(rst), .bus(bus_rr));
    sram_arbiter #(.BW(BW), .AW(AW), .RR(0)) dut_fp (.clk_i(clk), .rst_i(rst), .bus(bus_fp));

    // SRAM macro models (registered read, write on WEN low).
    logic [BW-1:0] mem_rr [1024];
    logic [BW-1:0] mem_fp [1024];
    always @(posedge clk) begin
        if (bus_rr.csn === 1'b0) begin
            if (bus_rr.wen === 1'b0) mem_rr[bus_rr.a] <= bus_rr.di;
            else                     bus_rr.dout      <= mem_rr[bus_rr.a];
        end
    end
    always @(posedge clk) begin
        if (bus_fp.csn === 1'b0) begin
            if (bus_fp.wen === 1'b0) mem_fp[bus_fp.a] <= bus_fp.di;
            else                     bus_fp.dout      <= mem_fp[bus_fp.a];
        end
    end

    // Observed outputs, index 0 = round-robin instance, 1 = fixed priority.
    logic [1:0]    o_gnt [2];
    logic [1:0]    o_rv  [2];
    logic          o_csn [2];
    logic          o_wen [2];
    logic [AW-1:0] o_a   [2];
    logic [BW-1:0] o_di  [2];
    logic [BW-1:0] o_rd0 [2];
    logic [BW-1:0] o_rd1 [2];
    assign o_gnt[0] = {bus_rr.gnt1, bus_rr.gnt0};
    assign o_gnt[1] = {bus_fp.gnt1, bus_fp.gnt0};
    assign o_rv[0]  = {bus_rr.rvalid1, bus_rr.rvalid0};
    assign o_rv[1]  = {bus_fp.rvalid1, bus_fp.rvalid0};
    assign o_csn[0] = bus_rr.csn;   assign o_csn[1] = bus_fp.csn;
    assign o_wen[0] = bus_rr.wen;   assign o_wen[1] = bus_fp.wen;
    assign o_a[0]   = bus_rr.a;     assign o_a[1]   = bus_fp.a;
    assign o_di[0]  = bus_rr.di;    assign o_di[1]  = bus_fp.di;
    assign o_rd0[0] = bus_rr.rdata0; assign o_rd0[1] = bus_fp.rdata0;
    assign o_rd1[0] = bus_rr.rdata1; assign o_rd1[1] = bus_fp.rdata1;

    // Reference model state.
    int            m_last  [2];
    logic          m_rv    [2][2];
    logic [BW-1:0] m_rdata [2][2];
    logic [BW-1:0] m_mem   [2][1024];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs at the negedge, then advance the model at the posedge.
    task automatic cycle();
        int   p [2];
        logic g [2];
        int   adr;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            g[k] = 1'b0;
            p[k] = 0;
            if (!rst) begin
                if (req0 && req1) begin
                    g[k] = 1'b1;
                    p[k] = (k == 0) ? ((m_last[k] == 1) ? 0 : 1) : 0;
                end else if (req0) begin
                    g[k] = 1'b1; p[k] = 0;
                end else if (req1) begin
                    g[k] = 1'b1; p[k] = 1;
                end
            end
            chk($sformatf("gnt[%0d]", k), 64'(o_gnt[k]), g[k] ? 64'(2'b01 << p[k]) : 64'd0);
            chk($sformatf("csn[%0d]", k), 64'(o_csn[k]), 64'(!g[k]));
            if (g[k]) begin
                chk($sformatf("wen[%0d]", k), 64'(o_wen[k]), 64'((p[k] == 1) ? !we1 : !we0));
                chk($sformatf("addr[%0d]", k), 64'(o_a[k]), 64'((p[k] == 1) ? a1 : a0));
                if ((p[k] == 1) ? we1 : we0)
                    chk($sformatf("di[%0d]", k), 64'(o_di[k]), 64'((p[k] == 1) ? di1 : di0));
            end else begin
                chk($sformatf("wen_idle[%0d]", k), 64'(o_wen[k]), 64'd1);
            end
            if (!rst) begin
                chk($sformatf("rvalid[%0d]", k), 64'(o_rv[k]), 64'({m_rv[k][1], m_rv[k][0]}));
                if (m_rv[k][0]) chk($sformatf("rdata0[%0d]", k), 64'(o_rd0[k]), 64'(m_rdata[k][0]));
                if (m_rv[k][1]) chk($sformatf("rdata1[%0d]", k), 64'(o_rd1[k]), 64'(m_rdata[k][1]));
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_rv[k][0] = 1'b0;
            m_rv[k][1] = 1'b0;
            if (rst) begin
                m_last[k] = 1;
            end else if (g[k]) begin
                adr = int'((p[k] == 1) ? a1 : a0);
                if ((p[k] == 1) ? we1 : we0) begin
                    m_mem[k][adr] = (p[k] == 1) ? di1 : di0;
                end else begin
                    m_rv[k][p[k]]    = 1'b1;
                    m_rdata[k][p[k]] = m_mem[k][adr];
                end
                m_last[k] = p[k];
            end
        end
        #1;
    endtask

    task automatic wr0(input logic [AW-1:0] adr, input logic [BW-1:0] dat);
        req0 = 1'b1; we0 = 1'b1; a0 = adr; di0 = dat;
        req1 = 1'b0;
        cycle();
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        a0 = '0; a1 = '0; di0 = '0; di1 = '0;

        // Reset held two cycles with both requests high.
        cycle();
        cycle();
        chk("rst_rvalid_rr", 64'(o_rv[0]), 64'd0);
        chk("rst_rvalid_fp", 64'(o_rv[1]), 64'd0);

        // Single write then read on port 0.
        rst = 1'b0;
        wr0(10'h005, 32'hDEADBEEF);
        we0 = 1'b0;
        cycle();
        chk("rd_rvalid0", 64'(bus_rr.rvalid0), 64'd1);
        chk("rd_rdata0", 64'(bus_rr.rdata0), 64'hDEADBEEF);
        chk("rd_rvalid1", 64'(bus_rr.rvalid1), 64'd0);

        // Preload for the contention and burst cases.
        wr0(10'h010, 32'h11);
        wr0(10'h020, 32'h22);
        for (int i = 0; i < 4; i++) wr0(10'(i), 32'hA0 + 32'(i));
        req0 = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Contention: both read, RR alternates, fixed priority stays on port 0.
        req0 = 1'b1; we0 = 1'b0; a0 = 10'h010;
        req1 = 1'b1; we1 = 1'b0; a1 = 10'h020;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_alt_rvalid", 64'(o_rv[0]), (i % 2 == 0) ? 64'd1 : 64'd2);
            chk("fp_rvalid", 64'(o_rv[1]), 64'd1);
        end
        req0 = 1'b0;
        cycle();
        chk("fp_gnt1_after_drop", 64'(bus_fp.rvalid1), 64'd1);
        chk("fp_rdata1", 64'(bus_fp.rdata1), 64'h22);

        // Back-to-back port-1 reads.
        req1 = 1'b1; we1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a1 = 10'(i);
            cycle();
            chk("b2b_rvalid1", 64'(bus_rr.rvalid1), 64'd1);
            chk("b2b_rdata1", 64'(bus_rr.rdata1), 64'hA0 + 64'(i));
        end

        // Reset arriving behind a granted read.
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; a0 = 10'h005;
        cycle();
        rst = 1'b1; req1 = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_mid_rvalid0", 64'(bus_rr.rvalid0), 64'd0);
        a1 = 10'h010;
        cycle();
        chk("post_rst_first_port0", 64'(bus_rr.rvalid0), 64'd1);

        // Fill a small address window, then randomized traffic.
        for (int i = 0; i < 16; i++) wr0(10'(i), $urandom);
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 39) == 0);
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 3) != 0);
            we0  = ($urandom_range(0, 2) == 0);
            we1  = ($urandom_range(0, 2) == 0);
            a0   = 10'($urandom_range(0, 15));
            a1   = 10'($urandom_range(0, 15));
            di0  = $urandom;
            di1  = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
